dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port, word-addressed data memory between two requesters:
//   port 0 = pipeline MEM stage, port 1 = debug/loader engine. Round-robin
//   arbitration, registered grant and read-data return, one access every 2
//   cycles at full load. Drives the memory's address/write-data/write-enable
//   pins in place of direct MEM-stage decode.
// PARAMETERS
//   DATA_W      32  data word width
//   ADDR_W      8   word-index width; memory depth = 2**ADDR_W (256)
//   FIXED_PRIO  0   0 = round-robin; 1 = port 0 always wins ties
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset
//   req0/req1  in   1       access request, level; hold until gntN seen
//   we0/we1    in   1       1 = write, 0 = read; valid while reqN=1
//   addr0/1    in   32      word address; only [ADDR_W-1:0] used
//   wdata0/1   in   DATA_W  write data
//   gnt0/gnt1  out  1       1-cycle pulse: request taken, memory being accessed
//   rvalid0/1  out  1       1-cycle pulse: access complete, rdataN valid
//   rdata0/1   out  DATA_W  read data (reads); holds last value otherwise
//   busy       out  1       1 when state != IDLE
//   mem_addr   out  ADDR_W  to memory address
//   mem_wdata  out  DATA_W  to memory write data
//   mem_we     out  1       to memory write enable
//   mem_rdata  in   DATA_W  memory combinational read data
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, last=1 (port 0 wins first tie),
//     all gnt/rvalid/mem_we=0, rdata0/1=0, mem_addr=0, mem_wdata=0, busy=0.
//   Pending transaction discarded; no memory write after reset asserts.
//   FSM states: IDLE, ACCESS, RESP.
//   IDLE: at an edge with any reqN=1, pick winner, latch we/addr/wdata/owner,
//     -> ACCESS. No request -> stay IDLE.
//   ACCESS (1 cycle): gnt[owner]=1; mem_addr/mem_wdata from latched values;
//     mem_we = latched we. At end-of-cycle edge, rdata[owner] <= mem_rdata
//     (reads only; writes leave rdata unchanged). -> RESP.
//   RESP (1 cycle): rvalid[owner]=1; last <= owner; mem_we=0. Same edge
//     re-arbitrates on current reqs with updated pointer: any req -> latch,
//     -> ACCESS (back-to-back); none -> IDLE.
//   Arbitration: one req -> it wins. Both -> FIXED_PRIO=1: port 0;
//     FIXED_PRIO=0: port != last. Decision is combinational on reqs in
//     IDLE/RESP; operands latched on the same edge.
//   Latency: req seen at edge E -> gnt in cycle E+1 -> rvalid in cycle E+2.
//   Requester drops req on the edge that ends its gnt cycle, else the
//     request is treated as a new access.
//   req dropped before acceptance: no effect, no gnt.
//   Requests in ACCESS are not sampled; they wait for RESP.
//   Address: mem_addr = addr[ADDR_W-1:0]; upper bits silently ignored (wrap).
//   mem_addr/mem_wdata hold last latched values outside ACCESS; mem_we is
//     1 only in ACCESS with latched we=1 (decoded from registered state).
//   gnt0&gnt1 and rvalid0&rvalid1 are never both 1 in any cycle.
// TESTING
//   1. req0,we0=1,addr0=0x05,wdata0=0xDEADBEEF at edge 0 -> cycle 1: gnt0,
//      mem_we=1, mem_addr=0x05; cycle 2: rvalid0. Then port 1 read
//      0x05 -> rvalid1 with rdata1=0xDEADBEEF.
//   2. FIXED_PRIO=0, req0 and req1 re-asserted after each gnt -> gnt order
//      0,1,0,1; one gnt every 2 cycles; busy stays 1.
//   3. FIXED_PRIO=1, same stimulus -> only gnt0; port 1 granted only in the
//      first RESP where req0=0.
//   4. Write in flight, reset=0 mid-ACCESS -> mem_we falls without a clock;
//      memory word unchanged; gnt/rvalid/busy=0; after release, tie -> port 0.
//   5. addr1=0x105 read, ADDR_W=8 -> mem_addr=0x05, rdata1 = word 5 contents.
//   6. req1 pulsed 1 cycle while in ACCESS serving port 0 -> never granted.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, word-addressed data memory between
// two requesters (port 0 = pipeline MEM stage, port 1 = debug/loader engine).
// Round-robin (or fixed port-0 priority) arbitration, registered operands,
// one memory access every two cycles under full load.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   req/we/addr/wdata N  per-port request, level-held until gntN is seen
//   gntN                 1-cycle pulse while the memory is being accessed
//   rvalidN, rdataN      1-cycle completion pulse; rdataN holds last read
//   busy                 arbiter not idle
//   mem_addr/wdata/we    memory pins, mem_rdata is combinational read data
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, next_state;
    logic   owner;      // port served by the current transaction
    logic   last;       // port served most recently (round-robin pointer)
    logic   lat_we;
    logic   take;       // accept a new request at this edge
    logic   pick;       // winning port when take=1
    logic   eff_last;

    // Upper address bits are intentionally dropped (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[31:ADDR_W], addr1[31:ADDR_W]};

    // In RESP the pointer update (last <= owner) happens on the same edge as
    // re-arbitration, so the decision uses the owner directly.
    assign eff_last = (state == RESP) ? owner : last;

    always_comb begin
        next_state = state;
        take       = 1'b0;
        pick       = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (req0 || req1) begin
                    take       = 1'b1;
                    next_state = ACCESS;
                    if (req0 && req1)
                        pick = (FIXED_PRIO != 0) ? 1'b0 : ~eff_last;
                    else
                        pick = req1;
                end else begin
                    next_state = IDLE;
                end
            end
            ACCESS:  next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state <= next_state;
            if (take) begin
                owner     <= pick;
                lat_we    <= pick ? we1 : we0;
                mem_addr  <= pick ? addr1[ADDR_W-1:0] : addr0[ADDR_W-1:0];
                mem_wdata <= pick ? wdata1 : wdata0;
            end
            if (state == RESP)
                last <= owner;
            if (state == ACCESS && !lat_we) begin
                if (owner)
                    rdata1 <= mem_rdata;
                else
                    rdata0 <= mem_rdata;
            end
        end
    end

    // Decoded from registered state so an asynchronous reset drops them at once.
    assign gnt0    = (state == ACCESS) && !owner;
    assign gnt1    = (state == ACCESS) &&  owner;
    assign rvalid0 = (state == RESP)   && !owner;
    assign rvalid1 = (state == RESP)   &&  owner;
    assign mem_we  = (state == ACCESS) &&  lat_we;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance a uses round-robin, instance b
// fixed port-0 priority. Each instance drives its own behavioural memory.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Instance a (round-robin)
    logic        req0_a, req1_a, we0_a, we1_a;
    logic [31:0] addr0_a, addr1_a, wdata0_a, wdata1_a;
    logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, busy_a, mem_we_a;
    logic [31:0] rdata0_a, rdata1_a, mem_wdata_a, mem_rdata_a;
    logic [7:0]  mem_addr_a;
    logic [31:0] mem_a [256];

    // Instance b (fixed priority)
    logic        req0_b, req1_b, we0_b, we1_b;
    logic [31:0] addr0_b, addr1_b, wdata0_b, wdata1_b;
    logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, busy_b, mem_we_b;
    logic [31:0] rdata0_b, rdata1_b, mem_wdata_b, mem_rdata_b;
    logic [7:0]  mem_addr_b;
    logic [31:0] mem_b [256];

    dmem_arbiter #(.DATA_W(32), .ADDR_W(8), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .reset(rst_n),
        .req0(req0_a), .req1(req1_a), .we0(we0_a), .we1(we1_a),
        .addr0(addr0_a), .addr1(addr1_a), .wdata0(wdata0_a), .wdata1(wdata1_a),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .rvalid0(rvalid0_a), .rvalid1(rvalid1_a),
        .rdata0(rdata0_a), .rdata1(rdata1_a), .busy(busy_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a),
        .mem_rdata(mem_rdata_a)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(8), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .reset(rst_n),
        .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
        .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b), .busy(busy_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
        .mem_rdata(mem_rdata_b)
    );

    assign mem_rdata_a = mem_a[mem_addr_a];
    assign mem_rdata_b = mem_b[mem_addr_b];

    always @(posedge clk) begin
        if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
        if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_b[3] = 32'hA5A5_0003;
        {req0_a, req1_a, we0_a, we1_a} = '0;
        {addr0_a, addr1_a, wdata0_a, wdata1_a} = '0;
        {req0_b, req1_b, we0_b, we1_b} = '0;
        {addr0_b, addr1_b, wdata0_b, wdata1_b} = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_gnt0",   {31'd0, gnt0_a},   32'd0);
        chk("rst_gnt1",   {31'd0, gnt1_a},   32'd0);
        chk("rst_rvalid", {30'd0, rvalid0_a, rvalid1_a}, 32'd0);
        chk("rst_busy",   {31'd0, busy_a},   32'd0);
        chk("rst_mem_we", {31'd0, mem_we_a}, 32'd0);
        chk("rst_rdata0", rdata0_a, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr_a}, 32'd0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1. Port 0 write 0xDEADBEEF to word 5, then port 1 reads it back
        req0_a = 1; we0_a = 1; addr0_a = 32'h05; wdata0_a = 32'hDEADBEEF;
        tick();
        chk("t1_gnt0",      {31'd0, gnt0_a},   32'd1);
        chk("t1_gnt1",      {31'd0, gnt1_a},   32'd0);
        chk("t1_mem_we",    {31'd0, mem_we_a}, 32'd1);
        chk("t1_mem_addr",  {24'd0, mem_addr_a}, 32'h05);
        chk("t1_mem_wdata", mem_wdata_a, 32'hDEADBEEF);
        chk("t1_busy",      {31'd0, busy_a}, 32'd1);
        req0_a = 0;
        tick();
        chk("t1_rvalid0",   {31'd0, rvalid0_a}, 32'd1);
        chk("t1_resp_we",   {31'd0, mem_we_a},  32'd0);
        chk("t1_resp_gnt0", {31'd0, gnt0_a},    32'd0);
        chk("t1_wr_rdata0", rdata0_a, 32'd0);
        req1_a = 1; we1_a = 0; addr1_a = 32'h05;
        tick();
        chk("t1_gnt1_rd",   {31'd0, gnt1_a},   32'd1);
        chk("t1_rd_we",     {31'd0, mem_we_a}, 32'd0);
        req1_a = 0;
        tick();
        chk("t1_rvalid1",   {31'd0, rvalid1_a}, 32'd1);
        chk("t1_rvalid0_lo",{31'd0, rvalid0_a}, 32'd0);
        chk("t1_rdata1",    rdata1_a, 32'hDEADBEEF);
        tick();
        chk("t1_idle",      {31'd0, busy_a}, 32'd0);

        // 5. Address wrap: 0x105 reaches word 5
        req1_a = 1; we1_a = 0; addr1_a = 32'h105;
        tick();
        chk("t5_mem_addr",  {24'd0, mem_addr_a}, 32'h05);
        req1_a = 0;
        tick();
        chk("t5_rvalid1",   {31'd0, rvalid1_a}, 32'd1);
        chk("t5_rdata1",    rdata1_a, 32'hDEADBEEF);
        tick();

        // 6. req1 pulsed only during port 0's ACCESS cycle is never granted
        req0_a = 1; we0_a = 0; addr0_a = 32'h05;
        tick();
        chk("t6_gnt0", {31'd0, gnt0_a}, 32'd1);
        req0_a = 0; req1_a = 1; we1_a = 0; addr1_a = 32'h07;
        tick();
        req1_a = 0;
        chk("t6_rvalid0", {31'd0, rvalid0_a}, 32'd1);
        chk("t6_rdata0",  rdata0_a, 32'hDEADBEEF);
        tick();
        chk("t6_no_gnt1", {31'd0, gnt1_a}, 32'd0);
        chk("t6_idle",    {31'd0, busy_a}, 32'd0);
        tick();
        chk("t6_no_gnt1b", {31'd0, gnt1_a}, 32'd0);

        // 4. Reset in the middle of a write
        req0_a = 1; we0_a = 1; addr0_a = 32'h09; wdata0_a = 32'hCAFEF00D;
        tick();
        chk("t4_mem_we_pre", {31'd0, mem_we_a}, 32'd1);
        req0_a = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("t4_mem_we_async", {31'd0, mem_we_a}, 32'd0);
        chk("t4_gnt0_async",   {31'd0, gnt0_a},   32'd0);
        chk("t4_busy_async",   {31'd0, busy_a},   32'd0);
        chk("t4_rdata1_clr",   rdata1_a, 32'd0);
        tick();
        chk("t4_mem_unchanged", mem_a[9], 32'd0);
        chk("t4_rvalid",       {30'd0, rvalid0_a, rvalid1_a}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 2. Round-robin with both ports requesting: order 0,1,0,1
        req0_a = 1; we0_a = 0; addr0_a = 32'h05;
        req1_a = 1; we1_a = 0; addr1_a = 32'h09;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_gnt0", {31'd0, gnt0_a}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_gnt1", {31'd0, gnt1_a}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("t2_busy_acc", {31'd0, busy_a}, 32'd1);
            if (i == 3) begin
                req0_a = 0;
                req1_a = 0;
            end
            tick();
            chk("t2_rvalid0", {31'd0, rvalid0_a}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_rvalid1", {31'd0, rvalid1_a}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("t2_busy_resp", {31'd0, busy_a}, 32'd1);
        end
        chk("t2_rdata0", rdata0_a, 32'hDEADBEEF);
        chk("t2_rdata1", rdata1_a, 32'd0);
        tick();
        chk("t2_idle", {31'd0, busy_a}, 32'd0);

        // 3. Fixed priority: port 0 wins every tie until it drops
        req0_b = 1; we0_b = 0; addr0_b = 32'h03;
        req1_b = 1; we1_b = 0; addr1_b = 32'h03;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_gnt0", {31'd0, gnt0_b}, 32'd1);
            chk("t3_gnt1", {31'd0, gnt1_b}, 32'd0);
            if (i == 2) req0_b = 0;
            tick();
            chk("t3_rvalid0", {31'd0, rvalid0_b}, 32'd1);
            chk("t3_busy", {31'd0, busy_b}, 32'd1);
        end
        chk("t3_rdata0", rdata0_b, 32'hA5A5_0003);
        tick();
        chk("t3_gnt1_late", {31'd0, gnt1_b}, 32'd1);
        chk("t3_gnt0_late", {31'd0, gnt0_b}, 32'd0);
        req1_b = 0;
        tick();
        chk("t3_rvalid1", {31'd0, rvalid1_b}, 32'd1);
        chk("t3_rdata1",  rdata1_b, 32'hA5A5_0003);
        tick();
        chk("t3_idle", {31'd0, busy_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
